// File: rtl/dmem_sram_ctrl.sv
// Data-memory controller between the MEM stage and a 16-bit asynchronous SRAM.
// Each access runs as setup, a timed strobe, then a one-cycle recovery; the pipeline is stalled until recovery.
//
// state  | meaning
// IDLE   | waiting for a load/store request; latches address, data and op on acceptance
// SETUP  | address (and store data) presented with CE_n low, strobes inactive
// ACCESS | OE_n (load) or WE_n (store) low while the wait counter runs down to zero
// DONE   | strobes released, address/store data held for hold time; never re-accepts
module dmem_sram_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wr_mem_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_data_o,
  output logic              sram_data_oe_o,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] RD_CNT = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_st_q, op_st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              doe_q, doe_d;
  logic              req;

  // codes 00 (load) and 01 (store) are the only requests; 1x is idle
  assign req = ~wr_mem_i[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_st_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_st_q <= op_st_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      doe_q   <= doe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_st_d = op_st_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SETUP;
          op_st_d = wr_mem_i[0];
          addr_d  = mem_addr_i;
          wdata_d = mem_data_i;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = op_st_q ? WR_CNT : RD_CNT;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!op_st_q) rdata_d = sram_data_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // SRAM pins are decoded from the next state so they change cleanly off a flop
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    doe_d  = 1'b0;
    case (state_d)
      SETUP: begin
        ce_n_d = 1'b0;
        doe_d  = op_st_d;
      end
      ACCESS: begin
        ce_n_d = 1'b0;
        oe_n_d = op_st_d;
        we_n_d = ~op_st_d;
        doe_d  = op_st_d;
      end
      DONE:    doe_d = op_st_d;
      default: doe_d = 1'b0;
    endcase
  end

  assign stallreq_o     = ((state_q == IDLE) && req) || (state_q == SETUP) || (state_q == ACCESS);
  assign mem_data_o     = rdata_q;
  assign sram_addr_o    = addr_q;
  assign sram_data_o    = wdata_q;
  assign sram_data_oe_o = doe_q;
  assign sram_ce_n_o    = ce_n_q;
  assign sram_oe_n_o    = oe_n_q;
  assign sram_we_n_o    = we_n_q;

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Directed bench for dmem_sram_ctrl: default-wait instance with an SRAM model,
// plus RD_WAIT=1 and RD_WAIT=15 instances driven together for the wait sweep.
module tb_dmem_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wr_mem = 2'b11;
  logic [15:0] addr = '0, wdata = '0;
  logic [15:0] mem_data, sram_addr, sram_wd, sram_rd;
  logic        stall, sram_doe, ce_n, oe_n, we_n;

  logic [1:0]  sw_wr = 2'b11;
  logic [15:0] sw_addr = '0, sw_wd = '0;
  logic [15:0] md1, sa1, sd1, rd1, md15, sa15, sd15, rd15;
  logic        st1, doe1, ce1, oe1, we1, st15, doe15, ce15, oe15, we15;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_sram_ctrl dut (
    .clk(clk), .rst(rst), .wr_mem_i(wr_mem), .mem_addr_i(addr), .mem_data_i(wdata),
    .mem_data_o(mem_data), .stallreq_o(stall), .sram_addr_o(sram_addr), .sram_data_o(sram_wd),
    .sram_data_oe_o(sram_doe), .sram_data_i(sram_rd), .sram_ce_n_o(ce_n),
    .sram_oe_n_o(oe_n), .sram_we_n_o(we_n));

  dmem_sram_ctrl #(.RD_WAIT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_mem_i(sw_wr), .mem_addr_i(sw_addr), .mem_data_i(sw_wd),
    .mem_data_o(md1), .stallreq_o(st1), .sram_addr_o(sa1), .sram_data_o(sd1),
    .sram_data_oe_o(doe1), .sram_data_i(rd1), .sram_ce_n_o(ce1),
    .sram_oe_n_o(oe1), .sram_we_n_o(we1));

  dmem_sram_ctrl #(.RD_WAIT(15)) dut15 (
    .clk(clk), .rst(rst), .wr_mem_i(sw_wr), .mem_addr_i(sw_addr), .mem_data_i(sw_wd),
    .mem_data_o(md15), .stallreq_o(st15), .sram_addr_o(sa15), .sram_data_o(sd15),
    .sram_data_oe_o(doe15), .sram_data_i(rd15), .sram_ce_n_o(ce15),
    .sram_oe_n_o(oe15), .sram_we_n_o(we15));

  // asynchronous SRAM: reads while CE/OE low, writes each cycle CE/WE low with bus driven
  assign sram_rd = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'h0000;
  assign rd1     = oe1  ? 16'h0000 : 16'h5A5A;
  assign rd15    = oe15 ? 16'h0000 : 16'h5A5A;

  always @(posedge clk) begin
    if (rst) mem[8'h40] <= 16'hBEEF;
    else if (!ce_n && !we_n && sram_doe) mem[sram_addr[7:0]] <= sram_wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request at posedge+1, samples at each negedge until the stall drops (DONE),
  // then returns at the following posedge+1 with the request withdrawn.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                        output int st, output int oe, output int we, output int ce,
                        output int doe, output logic fin);
    wr_mem = op; addr = a; wdata = d;
    st = 0; oe = 0; we = 0; ce = 0; doe = 0; fin = 1'b0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      if (stall) st++; else fin = 1'b1;
      if (!oe_n) oe++;
      if (!we_n) we++;
      if (!ce_n) ce++;
      if (sram_doe && sram_addr == a && sram_wd == d) doe++;
    end
    @(posedge clk); #1;
    wr_mem = 2'b11;
  endtask

  initial begin
    int st, oe, we, ce, doe;
    logic fin;
    int s1, o1, s15, o15;
    logic f1, f15, seen;

    #12;
    chk("rst_ce_n", ce_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_doe", sram_doe, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // single load
    run_op(2'b00, 16'h0040, 16'h0000, st, oe, we, ce, doe, fin);
    chk("ld_fin", fin, 1);
    chk("ld_stall", st, 4);
    chk("ld_oe_low", oe, 2);
    chk("ld_we_low", we, 0);
    chk("ld_ce_low", ce, 3);
    chk("ld_doe", doe, 0);
    chk("ld_data", mem_data, 16'hBEEF);

    // single store
    run_op(2'b01, 16'h0102, 16'h1234, st, oe, we, ce, doe, fin);
    chk("st_fin", fin, 1);
    chk("st_stall", st, 4);
    chk("st_we_low", we, 2);
    chk("st_oe_low", oe, 0);
    chk("st_bus_held", doe, 4);
    chk("st_mem", mem[8'h02], 16'h1234);
    chk("st_mem_data_kept", mem_data, 16'hBEEF);

    // back-to-back store then load of the same address
    run_op(2'b01, 16'h0010, 16'h00AA, st, oe, we, ce, doe, fin);
    chk("b2b_st_stall", st, 4);
    chk("b2b_st_we_low", we, 2);
    run_op(2'b00, 16'h0010, 16'h0000, s1, oe, we, ce, doe, fin);
    chk("b2b_total_stall", st + s1, 8);
    chk("b2b_ld_we_low", we, 0);
    chk("b2b_ld_data", mem_data, 16'h00AA);

    // reserved and idle codes
    for (int i = 0; i < 10; i++) begin
      wr_mem = (i < 5) ? 2'b10 : 2'b11;
      @(negedge clk);
      chk("idle_stall", stall, 0);
      chk("idle_ce_n", ce_n, 1);
      chk("idle_strobes", {oe_n, we_n, sram_doe}, 3'b110);
      @(posedge clk); #1;
    end

    // wait sweep: RD_WAIT=1 and RD_WAIT=15 loading together
    sw_wr = 2'b00; sw_addr = 16'h0033;
    s1 = 0; o1 = 0; s15 = 0; o15 = 0; f1 = 1'b0; f15 = 1'b0;
    for (int i = 0; i < 40 && !f15; i++) begin
      @(negedge clk);
      if (!f1) begin
        if (st1) s1++; else f1 = 1'b1;
        if (!oe1) o1++;
      end
      if (st15) s15++; else f15 = 1'b1;
      if (!oe15) o15++;
    end
    sw_wr = 2'b11;
    chk("w1_stall", s1, 3);
    chk("w1_oe_low", o1, 1);
    chk("w15_fin", f15, 1);
    chk("w15_stall", s15, 17);
    chk("w15_oe_low", o15, 15);
    chk("w15_data", md15, 16'h5A5A);
    repeat (25) @(posedge clk);
    #1;
    chk("w1_data", md1, 16'h5A5A);

    // asynchronous reset in the middle of a store strobe
    run_op(2'b11, 16'h0000, 16'h0000, st, oe, we, ce, doe, fin);
    wr_mem = 2'b01; addr = 16'h0020; wdata = 16'h7777;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (!we_n) seen = 1'b1;
    end
    chk("ar_we_seen", seen, 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_we_n", we_n, 1);
    chk("ar_ce_n", ce_n, 1);
    chk("ar_doe", sram_doe, 0);
    chk("ar_mem_data", mem_data, 0);
    chk("ar_addr", sram_addr, 0);
    chk("ar_stall_req", stall, 1);
    wr_mem = 2'b11;
    #1;
    chk("ar_stall_idle", stall, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_ce_n", ce_n, 1);
    chk("post_rst_stall", stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
